// File: rtl/rx_pkt_ctrl.sv
// Framed packet receiver: SOF, LEN, payload, XOR checksum, then drains the
// buffered payload over a valid/ready port. Optional watchdog: RX_TIMEOUT_EN.
module rx_pkt_ctrl #(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] SOF     = 8'hAA,
  parameter int         TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_ovf,
  output logic       err_tout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] len;
  logic [3:0] idx;
  logic [3:0] rd_idx;
  logic [7:0] chk;
  logic [7:0] buffer [0:15];
  logic       tout_hit;

  function automatic logic [7:0] chk_next(input logic [7:0] c, input logic [7:0] d);
    return c ^ d;
  endfunction

`ifdef RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;

  // Idle-time counter; only advances while a frame is being collected.
  always_comb begin
    tout_hit = 1'b0;
    if (!rx_done && (state == LEN || state == PAYLOAD || state == CHK) &&
        tcnt == CW'(TIMEOUT - 1)) begin
      tout_hit = 1'b1;
    end else begin
      tout_hit = 1'b0;
    end
  end

  // Counter clears on any received byte and whenever no frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt     <= '0;
      err_tout <= 1'b0;
    end else begin
      err_tout <= tout_hit;
      if (rx_done || state == IDLE || state == DRAIN) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + CW'(1);
      end
    end
  end
`else
  assign tout_hit = 1'b0;
  assign err_tout = 1'b0;
`endif

  // Payload storage carries no reset; only written indices are ever read.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_done) begin
      buffer[idx] <= rx_data;
    end
  end

  // Main frame FSM with registered outputs and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= 4'd0;
      idx       <= 4'd0;
      rd_idx    <= 4'd0;
      chk       <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
      err_chk   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      err_chk <= 1'b0;
      err_ovf <= 1'b0;
      if (tout_hit) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_done && rx_data == SOF) begin
              state  <= LEN;
              busy   <= 1'b1;
              idx    <= 4'd0;
              rd_idx <= 4'd0;
            end
          end
          LEN: begin
            if (rx_done) begin
              if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                err_len <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
              end else begin
                len   <= rx_data[3:0];
                chk   <= rx_data;
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (rx_done) begin
              chk <= chk_next(chk, rx_data);
              idx <= idx + 4'd1;
              if (idx == len - 4'd1) begin
                state <= CHK;
              end
            end
          end
          CHK: begin
            if (rx_done) begin
              if (rx_data == chk) begin
                state     <= DRAIN;
                rd_idx    <= 4'd0;
                out_valid <= 1'b1;
                out_data  <= buffer[0];
                out_last  <= (len == 4'd1);
              end else begin
                err_chk <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
              end
            end
          end
          DRAIN: begin
            // Bytes arriving while draining cannot be stored.
            if (rx_done) begin
              err_ovf <= 1'b1;
            end
            if (out_valid && out_ready) begin
              if (out_last) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                rd_idx   <= rd_idx + 4'd1;
                out_data <= buffer[rd_idx + 4'd1];
                out_last <= ((rd_idx + 4'd1) == (len - 4'd1));
              end
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Directed bench for rx_pkt_ctrl; expected values are hand-computed constants.
module tb_rx_pkt_ctrl;

`ifdef RX_TIMEOUT_EN
  localparam int TOUT = 20;
`else
  localparam int TOUT = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, busy;
  logic       err_len, err_chk, err_ovf, err_tout;

  int n_checks = 0;
  int n_fail   = 0;

  rx_pkt_ctrl #(.MAX_LEN(8), .SOF(8'hAA), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_len(err_len), .err_chk(err_chk),
    .err_ovf(err_ovf), .err_tout(err_tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rx_done strobe; returns at the negedge after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    check({tag, "_data"}, {8'd0, out_data}, {8'd0, d});
    check({tag, "_last"}, {15'd0, out_last}, {15'd0, l});
  endtask

  task automatic run_pkt3(input string tag);
    send(8'hAA);
    check({tag, "_busy_len"}, {15'd0, busy}, 16'd1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h03);
    check_out({tag, "_b0"}, 8'h11, 1'b0);
    @(negedge clk);
    check_out({tag, "_b1"}, 8'h22, 1'b0);
    @(negedge clk);
    check_out({tag, "_b2"}, 8'h33, 1'b1);
    @(negedge clk);
    check({tag, "_valid_after"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_busy_after"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #12;
    check("rst_data", {8'd0, out_data}, 16'h0000);
    check("rst_flags", {9'd0, out_valid, out_last, busy, err_len, err_chk, err_ovf, err_tout}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    send(8'h3C);
    check("idle_ignore", {15'd0, busy}, 16'd0);

    run_pkt3("pkt3");

    // Checksum 02^10^20 = 32, 00 is a mismatch
    out_ready = 1'b1;
    send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    check("chk_err", {15'd0, err_chk}, 16'd1);
    check("chk_busy", {15'd0, busy}, 16'd0);
    check("chk_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check("chk_err_gone", {15'd0, err_chk}, 16'd0);

    send(8'hAA); send(8'h00);
    check("len0_err", {15'd0, err_len}, 16'd1);
    check("len0_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    check("len0_gone", {15'd0, err_len}, 16'd0);
    send(8'hAA); send(8'h09);
    check("len9_err", {15'd0, err_len}, 16'd1);
    check("len9_valid", {15'd0, out_valid}, 16'd0);

    // Minimum length: chk = 01^5A = 5B
    send(8'hAA); send(8'h01); send(8'h5A); send(8'h5B);
    check_out("len1", 8'h5A, 1'b1);
    @(negedge clk);
    check("len1_done", {15'd0, out_valid}, 16'd0);

    // Stall: chk = 02^A1^B2 = 11
    out_ready = 1'b0;
    send(8'hAA); send(8'h02); send(8'hA1); send(8'hB2); send(8'h11);
    for (int i = 0; i < 5; i++) begin
      check_out("stall", 8'hA1, 1'b0);
      @(negedge clk);
    end
    send(8'h55);
    check("ovf_err", {15'd0, err_ovf}, 16'd1);
    check_out("ovf_hold", 8'hA1, 1'b0);
    @(negedge clk);
    check("ovf_gone", {15'd0, err_ovf}, 16'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("stall_b1", 8'hB2, 1'b1);
    @(negedge clk);
    check("stall_done", {15'd0, busy}, 16'd0);

    send(8'hAA); send(8'h04); send(8'h01);
`ifdef RX_TIMEOUT_EN
    repeat (TOUT - 1) @(negedge clk);
    check("tout_early", {15'd0, err_tout}, 16'd0);
    check("tout_busy_early", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check("tout_err", {15'd0, err_tout}, 16'd1);
    check("tout_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    check("tout_gone", {15'd0, err_tout}, 16'd0);
`else
    repeat (1000) @(negedge clk);
    check("no_tout_busy", {15'd0, busy}, 16'd1);
    check("no_tout_err", {15'd0, err_tout}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    send(8'hAA); send(8'h03); send(8'h11);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_out", {7'd0, out_valid, out_data}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_quiet", {12'd0, err_len, err_chk, err_ovf, out_valid}, 16'd0);
    run_pkt3("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
